// File: rtl/spi_flash_mux_n.sv
// N-way SPI flash router: host SPI fanned out under an enable mask, MISO returned
// from one chip; mask/source changes only land after a guarded CS# idle window.
module spi_flash_mux_n #(
  parameter int unsigned          NUM_FLASH    = 4,
  parameter int unsigned          SRC_W        = 2,
  parameter int unsigned          SYNC_STAGES  = 2,
  parameter int unsigned          GUARD_CYCLES = 4,
  parameter int unsigned          PEND_TIMEOUT = 1024,
  parameter logic [NUM_FLASH-1:0] RESET_MASK   = NUM_FLASH'(1),
  parameter logic [SRC_W-1:0]     RESET_SRC    = '0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 h_clk,
  input  logic                 h_cs_n,
  input  logic                 h_mosi,
  output logic                 h_miso,
  output logic [NUM_FLASH-1:0] f_clk,
  output logic [NUM_FLASH-1:0] f_cs_n,
  output logic [NUM_FLASH-1:0] f_mosi,
  input  logic [NUM_FLASH-1:0] f_miso,
  input  logic [NUM_FLASH-1:0] sel_mask,
  input  logic [SRC_W-1:0]     miso_src,
  input  logic                 clr_err,
  output logic [NUM_FLASH-1:0] active_mask,
  output logic [SRC_W-1:0]     active_src,
  output logic                 switch_pending,
  output logic [15:0]          switch_count,
  output logic                 pend_timeout
);

  localparam int unsigned IDLE_W = $clog2(GUARD_CYCLES + 1);
  localparam int unsigned PEND_W = $clog2(PEND_TIMEOUT + 1);
  localparam logic [IDLE_W-1:0] GUARD_MAX = IDLE_W'(GUARD_CYCLES);
  localparam logic [PEND_W-1:0] PEND_MAX  = PEND_W'(PEND_TIMEOUT);
  localparam logic [SRC_W:0]    SRC_LIM   = (SRC_W + 1)'(NUM_FLASH);

  typedef enum logic {STABLE, PENDING} state_t;

  state_t                 state, state_n;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   cs_sync;
  logic [IDLE_W-1:0]      idle_cnt;
  logic [PEND_W-1:0]      pend_cnt, pend_n;
  logic [SRC_W-1:0]       req_src;
  logic                   request, safe, apply, to_set;

  assign f_clk  = active_mask & {NUM_FLASH{h_clk}};
  assign f_cs_n = ~active_mask | {NUM_FLASH{h_cs_n}};
  assign f_mosi = active_mask & {NUM_FLASH{h_mosi}};
  assign h_miso = active_mask[active_src] & f_miso[active_src];

  assign req_src = ({1'b0, miso_src} < SRC_LIM) ? miso_src : '0;
  assign request = {sel_mask, req_src} != {active_mask, active_src};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync_q <= '1;
    else     sync_q <= {sync_q[SYNC_STAGES-2:0], h_cs_n};
  end
  assign cs_sync = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                  idle_cnt <= '0;
    else if (!cs_sync)        idle_cnt <= '0;
    else if (idle_cnt != GUARD_MAX) idle_cnt <= idle_cnt + 1'b1;
  end

  // Raw CS is also required so a CS fall still in the synchroniser blocks the switch.
  assign safe = (idle_cnt == GUARD_MAX) & cs_sync & h_cs_n;

  always_comb begin
    state_n = state;
    pend_n  = pend_cnt;
    apply   = 1'b0;
    case (state)
      STABLE: begin
        if (request && safe) begin
          apply = 1'b1;
        end else if (request) begin
          state_n = PENDING;
          pend_n  = PEND_W'(1);
        end
      end
      PENDING: begin
        if (!request) begin
          state_n = STABLE;
          pend_n  = '0;
        end else if (safe) begin
          apply   = 1'b1;
          state_n = STABLE;
          pend_n  = '0;
        end else if (pend_cnt != PEND_MAX) begin
          pend_n = pend_cnt + 1'b1;
        end
      end
      default: begin
        state_n = STABLE;
        pend_n  = '0;
      end
    endcase
  end

  assign to_set = (state_n == PENDING) && (pend_n == PEND_MAX);
  assign switch_pending = (state == PENDING);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= STABLE;
      pend_cnt     <= '0;
      active_mask  <= RESET_MASK;
      active_src   <= RESET_SRC;
      switch_count <= '0;
      pend_timeout <= 1'b0;
    end else begin
      state    <= state_n;
      pend_cnt <= pend_n;
      if (apply) begin
        active_mask <= sel_mask;
        active_src  <= req_src;
        if (switch_count != '1) switch_count <= switch_count + 16'd1;
      end
      if (to_set)       pend_timeout <= 1'b1;
      else if (clr_err) pend_timeout <= 1'b0;
    end
  end

endmodule

// File: tb/tb_spi_flash_mux_n.sv
// Directed bench for spi_flash_mux_n: a 4-chip instance for routing/guard timing and
// a 3-chip instance (PEND_TIMEOUT=8) for timeout and source clamping.
module tb_spi_flash_mux_n;

  logic clk = 1'b0;
  logic rst;
  logic h_clk, h_cs_n, h_mosi, clr_err;

  logic       h_miso;
  logic [3:0] f_clk, f_cs_n, f_mosi, f_miso, sel_mask, active_mask;
  logic [1:0] miso_src, active_src;
  logic       switch_pending, pend_timeout;
  logic [15:0] switch_count;

  logic       h_miso3;
  logic [2:0] f_clk3, f_cs_n3, f_mosi3, f_miso3, sel_mask3, active_mask3;
  logic [1:0] miso_src3, active_src3;
  logic       switch_pending3, pend_timeout3;
  logic [15:0] switch_count3;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  spi_flash_mux_n #(
    .NUM_FLASH(4), .SRC_W(2), .SYNC_STAGES(2), .GUARD_CYCLES(4),
    .PEND_TIMEOUT(1024), .RESET_MASK(4'b0001), .RESET_SRC(2'd0)
  ) dut (
    .clk(clk), .rst(rst), .h_clk(h_clk), .h_cs_n(h_cs_n), .h_mosi(h_mosi),
    .h_miso(h_miso), .f_clk(f_clk), .f_cs_n(f_cs_n), .f_mosi(f_mosi),
    .f_miso(f_miso), .sel_mask(sel_mask), .miso_src(miso_src), .clr_err(clr_err),
    .active_mask(active_mask), .active_src(active_src),
    .switch_pending(switch_pending), .switch_count(switch_count),
    .pend_timeout(pend_timeout)
  );

  spi_flash_mux_n #(
    .NUM_FLASH(3), .SRC_W(2), .SYNC_STAGES(2), .GUARD_CYCLES(4),
    .PEND_TIMEOUT(8), .RESET_MASK(3'b001), .RESET_SRC(2'd0)
  ) dut3 (
    .clk(clk), .rst(rst), .h_clk(h_clk), .h_cs_n(h_cs_n), .h_mosi(h_mosi),
    .h_miso(h_miso3), .f_clk(f_clk3), .f_cs_n(f_cs_n3), .f_mosi(f_mosi3),
    .f_miso(f_miso3), .sel_mask(sel_mask3), .miso_src(miso_src3), .clr_err(clr_err),
    .active_mask(active_mask3), .active_src(active_src3),
    .switch_pending(switch_pending3), .switch_count(switch_count3),
    .pend_timeout(pend_timeout3)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; h_clk = 1'b0; h_cs_n = 1'b1; h_mosi = 1'b0; clr_err = 1'b0;
    sel_mask = 4'b0001; miso_src = 2'd0; f_miso = 4'b0001;
    sel_mask3 = 3'b001; miso_src3 = 2'd0; f_miso3 = 3'b001;
    step(3);
    check("rst_mask",    32'(active_mask), 32'h1);
    check("rst_src",     32'(active_src), 32'h0);
    check("rst_count",   32'(switch_count), 32'h0);
    check("rst_pending", 32'(switch_pending), 32'h0);
    check("rst_timeout", 32'(pend_timeout), 32'h0);
    check("rst_miso",    32'(h_miso), 32'h1);
    rst = 1'b0;

    // routing follows host on chip 0 only
    h_cs_n = 1'b0; h_clk = 1'b1; h_mosi = 1'b1;
    #1;
    check("route_cs",   32'(f_cs_n), 32'b1110);
    check("route_clk",  32'(f_clk),  32'b0001);
    check("route_mosi", 32'(f_mosi), 32'b0001);
    h_cs_n = 1'b1;
    step(10);

    // idle switch: mask 0101, src 2
    sel_mask = 4'b0101; miso_src = 2'd2; f_miso = 4'b0100;
    #1;
    check("idle_hold_mask", 32'(active_mask), 32'h1);
    step(1);
    check("idle_mask",    32'(active_mask), 32'b0101);
    check("idle_src",     32'(active_src), 32'd2);
    check("idle_count",   32'(switch_count), 32'd1);
    check("idle_pending", 32'(switch_pending), 32'd0);
    check("idle_miso_hi", 32'(h_miso), 32'd1);
    check("idle_fclk",    32'(f_clk), 32'b0101);
    f_miso = 4'b1011;
    #1;
    check("idle_miso_lo", 32'(h_miso), 32'd0);

    // request during a transaction waits for the guard window
    h_cs_n = 1'b0; sel_mask = 4'b1000; miso_src = 2'd3; f_miso = 4'b1000;
    step(1);
    check("busy_pending", 32'(switch_pending), 32'd1);
    check("busy_mask",    32'(active_mask), 32'b0101);
    step(1);
    h_cs_n = 1'b1;
    step(6);
    check("guard_pending", 32'(switch_pending), 32'd1);
    check("guard_mask",    32'(active_mask), 32'b0101);
    step(1);
    check("guard_apply_mask", 32'(active_mask), 32'b1000);
    check("guard_apply_src",  32'(active_src), 32'd3);
    check("guard_count",      32'(switch_count), 32'd2);
    check("guard_pend_clr",   32'(switch_pending), 32'd0);
    check("guard_miso",       32'(h_miso), 32'd1);
    check("guard_no_timeout", 32'(pend_timeout), 32'd0);

    // reverted request drops without a switch
    h_cs_n = 1'b0; sel_mask = 4'b0011;
    step(1);
    check("rev_pending", 32'(switch_pending), 32'd1);
    step(2);
    sel_mask = 4'b1000;
    step(1);
    check("rev_pend_clr", 32'(switch_pending), 32'd0);
    h_cs_n = 1'b1;
    step(10);
    check("rev_mask",  32'(active_mask), 32'b1000);
    check("rev_count", 32'(switch_count), 32'd2);

    // timeout on the 3-chip instance
    h_cs_n = 1'b0; sel_mask3 = 3'b110;
    step(1);
    check("to_pending", 32'(switch_pending3), 32'd1);
    step(6);
    check("to_before", 32'(pend_timeout3), 32'd0);
    clr_err = 1'b1;
    step(1);
    clr_err = 1'b0;
    check("to_set_wins", 32'(pend_timeout3), 32'd1);
    step(12);
    check("to_sticky",  32'(pend_timeout3), 32'd1);
    check("to_held",    32'(active_mask3), 32'b001);
    check("to_main_ok", 32'(switch_pending), 32'd0);
    h_cs_n = 1'b1;
    step(6);
    check("to_wait", 32'(switch_pending3), 32'd1);
    step(1);
    check("to_apply_mask",  32'(active_mask3), 32'b110);
    check("to_apply_count", 32'(switch_count3), 32'd1);
    check("to_after_apply", 32'(pend_timeout3), 32'd1);
    clr_err = 1'b1;
    step(1);
    clr_err = 1'b0;
    check("to_cleared", 32'(pend_timeout3), 32'd0);

    // out-of-range source clamps to 0
    sel_mask3 = 3'b011; miso_src3 = 2'd2;
    step(1);
    check("clamp_pre_src", 32'(active_src3), 32'd2);
    miso_src3 = 2'd3;
    step(1);
    check("clamp_src",   32'(active_src3), 32'd0);
    check("clamp_count", 32'(switch_count3), 32'd3);
    check("clamp_miso",  32'(h_miso3), 32'd1);

    // async reset while pending
    h_cs_n = 1'b0; sel_mask = 4'b0010;
    step(1);
    check("prerst_pending", 32'(switch_pending), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("arst_mask",    32'(active_mask), 32'h1);
    check("arst_src",     32'(active_src), 32'h0);
    check("arst_count",   32'(switch_count), 32'h0);
    check("arst_pending", 32'(switch_pending), 32'h0);
    check("arst_mask3",   32'(active_mask3), 32'b001);
    check("arst_count3",  32'(switch_count3), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
